// File: rtl/wisc_mem_pkg.sv
// rtl/wisc_mem_pkg.sv - shared types and constants for the MEM-stage access controller
package wisc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  localparam int          MAX_WAIT_DEFAULT   = 15;
  localparam logic [15:0] TIMEOUT_LOAD_VALUE = 16'h0000;

endpackage

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data memory access controller with stall and timeout
module mem_access_ctrl
  import wisc_mem_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_to_reg_in,
  input  logic        reg_to_mem_in,
  input  logic [3:0]  reg_rd_in,
  input  logic [15:0] alu_result_in,
  input  logic [15:0] save_word_data_in,
  input  logic        ret_future_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        stall_out,
  output logic [15:0] wb_data_out,
  output logic [3:0]  wb_rd_out,
  output logic        wb_mem_to_reg_out,
  output logic        ret_future_out,
  output logic        err_timeout
);

  localparam logic [3:0] LAST_WAIT = 4'(MAX_WAIT - 1);

  mem_state_e  state_q, state_d;
  logic [3:0]  wait_cnt_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic [3:0]  rd_q;
  logic        ret_future_q;
  logic        is_load_q;
  logic        err_q;

  logic mem_op;
  logic timeout_hit;

  assign mem_op      = mem_to_reg_in | reg_to_mem_in;
  assign timeout_hit = (wait_cnt_q == LAST_WAIT) && !dmem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 4'd0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      rdata_q      <= 16'h0000;
      rd_q         <= 4'd0;
      ret_future_q <= 1'b0;
      is_load_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (mem_op) begin
            addr_q       <= alu_result_in;
            wdata_q      <= save_word_data_in;
            rd_q         <= reg_rd_in;
            ret_future_q <= ret_future_in;
            // A load request wins when both flags are set; the store is dropped.
            is_load_q    <= mem_to_reg_in;
            wait_cnt_q   <= 4'd0;
          end
        end
        ST_ACCESS: begin
          wait_cnt_q <= wait_cnt_q + 4'd1;
          if (dmem_ack) begin
            if (is_load_q) rdata_q <= dmem_rdata;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= TIMEOUT_LOAD_VALUE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (mem_op) state_d = ST_ACCESS;
      ST_ACCESS: if (dmem_ack || timeout_hit) state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dmem_req          = 1'b0;
    dmem_we           = 1'b0;
    dmem_addr         = 16'h0000;
    dmem_wdata        = 16'h0000;
    stall_out         = 1'b0;
    wb_data_out       = 16'h0000;
    wb_rd_out         = 4'd0;
    wb_mem_to_reg_out = 1'b0;
    ret_future_out    = 1'b0;
    err_timeout       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          stall_out = 1'b1;
        end else begin
          wb_data_out       = alu_result_in;
          wb_rd_out         = reg_rd_in;
          wb_mem_to_reg_out = mem_to_reg_in;
          ret_future_out    = ret_future_in;
        end
      end
      ST_ACCESS: begin
        dmem_req   = 1'b1;
        dmem_we    = !is_load_q;
        dmem_addr  = addr_q;
        dmem_wdata = wdata_q;
        stall_out  = 1'b1;
      end
      ST_DONE: begin
        wb_data_out       = is_load_q ? rdata_q : addr_q;
        wb_rd_out         = rd_q;
        wb_mem_to_reg_out = is_load_q;
        ret_future_out    = ret_future_q;
      end
      default: ;
    endcase
    // Reset blanks every output, including the IDLE pass-through path.
    if (rst) begin
      dmem_req          = 1'b0;
      dmem_we           = 1'b0;
      dmem_addr         = 16'h0000;
      dmem_wdata        = 16'h0000;
      stall_out         = 1'b0;
      wb_data_out       = 16'h0000;
      wb_rd_out         = 4'd0;
      wb_mem_to_reg_out = 1'b0;
      ret_future_out    = 1'b0;
      err_timeout       = 1'b0;
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum cycles in ACCESS without dmem_ack before timeout.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_to_reg_in  input  1  load request from EX/MEM register.
REQ-005 reg_to_mem_in  input  1  store request from EX/MEM register.
REQ-006 reg_rd_in  input  4  destination register of the in-flight instruction.
REQ-007 alu_result_in  input  16  memory address, or pass-through result for non-memory ops.
REQ-008 save_word_data_in  input  16  store data.
REQ-009 ret_future_in  input  1  future ret_wb flag, passed through.
REQ-010 dmem_req  output  1  data memory request, held until dmem_ack.
REQ-011 dmem_we  output  1  1 = write, 0 = read; valid while dmem_req = 1.
REQ-012 dmem_addr  output  16  memory address; valid while dmem_req = 1.
REQ-013 dmem_wdata  output  16  memory write data; valid while dmem_req = 1.
REQ-014 dmem_ack  input  1  memory completion strobe, one cycle.
REQ-015 dmem_rdata  input  16  read data; valid in the dmem_ack cycle.
REQ-016 stall_out  output  1  freezes EX/MEM and all upstream stages.
REQ-017 wb_data_out  output  16  result for MEM/WB register.
REQ-018 wb_rd_out  output  4  destination register for MEM/WB.
REQ-019 wb_mem_to_reg_out  output  1  load-completed flag for MEM/WB.
REQ-020 ret_future_out  output  1  ret_wb flag for MEM/WB.
REQ-021 err_timeout  output  1  sticky timeout flag.

Function
REQ-022 FSM states: IDLE, ACCESS, DONE.
REQ-023 IDLE, no memory op: stall_out = 0; wb_* and ret_future_out driven combinationally from inputs; wb_data_out = alu_result_in; zero added latency.
REQ-024 IDLE with mem_to_reg_in or reg_to_mem_in: latch addr, wdata, rd, ret_future and op type; stall_out = 1 combinationally; next state ACCESS.
REQ-025 Both mem_to_reg_in and reg_to_mem_in = 1: treat as load; suppress the store (dmem_we = 0).
REQ-026 ACCESS: dmem_req = 1; dmem_we, dmem_addr, dmem_wdata from latched registers, stable until ack; stall_out = 1; 4-bit wait counter increments each cycle.
REQ-027 ACCESS with dmem_ack: capture dmem_rdata if load; next state DONE.
REQ-028 ACCESS, counter = MAX_WAIT-1, no ack: next state DONE; set err_timeout; load result forced to 16'h0000.
REQ-029 DONE: stall_out = 0; dmem_req = 0; outputs driven from latched registers.
REQ-029a DONE output values: wb_data_out = captured rdata for a load, latched address for a store; wb_mem_to_reg_out = 1 for a load only.
REQ-030 DONE always returns to IDLE; EX/MEM inputs are not re-evaluated in DONE.
REQ-031 Minimum memory-op occupancy: 3 cycles (issue, one ACCESS, DONE).
REQ-032 dmem_ack in IDLE or DONE is ignored; it changes no state or output.
REQ-033 Wait counter clears on entry to ACCESS.
REQ-034 Counter width is fixed at 4 bits; MAX_WAIT is legal in the range 1..15.

Reset
REQ-035 rst = 1: next state IDLE; wait counter 0; latched registers 0; err_timeout 0.
REQ-036 While rst = 1, all outputs are 0, overriding REQ-023.
REQ-037 rst during ACCESS abandons the access; dmem_req = 0 from the rst cycle onward; a later ack is ignored per REQ-032.

Structure
REQ-038 Shared package wisc_mem_pkg holds the FSM state enum, MAX_WAIT default and the timeout load value 16'h0000.
REQ-039 Single module; no sub-module.

Verification
REQ-040 Scenario: ALU op, alu_result_in = 16'h1234, rd = 3, IDLE -> same cycle wb_data_out = 16'h1234, wb_rd_out = 3, stall_out = 0.
REQ-041 Scenario: load at 16'h0040; ack after 2 ACCESS cycles with rdata = 16'hBEEF -> stall_out = 1 for 3 cycles; DONE wb_data_out = 16'hBEEF, wb_mem_to_reg_out = 1.
REQ-042 Scenario: store data 16'h00AA to 16'h0010; ack on first ACCESS cycle -> dmem_we = 1, dmem_wdata = 16'h00AA for exactly 1 cycle; total stall 2 cycles.
REQ-043 Scenario: load, no ack, MAX_WAIT = 4 -> 4 ACCESS cycles; DONE wb_data_out = 16'h0000; err_timeout = 1 until rst.
REQ-044 Scenario: rst pulse in the 2nd ACCESS cycle, then ack one cycle later -> dmem_req = 0, state IDLE, ack ignored, all outputs 0 during rst.
REQ-045 Scenario: both mem flags = 1, addr 16'h0020 -> dmem_we = 0; result handled as a load.
